tmds_align_ctrl: RTL and testbench
==================================

Name: tmds_align_ctrl

Overview:
- Word-alignment controller for the HDMI raw capture path, running in the recovered pixel clock domain.
- Watches raw 10-bit channel-0 words for TMDS control tokens and sequences a search over word phase (bit slip) and PLL delay until tokens appear at the expected rate.
- Drives `pll_delay` into the PLL and `slip`/`slip_phase` into the sync recognizer.
- Holds `aligned` while the alignment stays good and re-searches when it degrades.

Parameters:
- WINDOW, 4096: measurement window length in clk cycles (≥ 1 video line).
- THRESH, 64: minimum control-token hits per window to count as a good window.
- SETTLE, 256: clk cycles ignored after any `pll_delay` or `slip` change.
- LOSS_WINDOWS, 4: consecutive bad windows in LOCKED before re-search.
- DEFAULT_DELAY, 0: reset/initial `pll_delay` value (4 bits).

Ports:
- clk  in  1  recovered TMDS pixel clock.
- reset  in  1  synchronous, active-high reset.
- locked  in  1  PLL lock indicator; treated as level, synchronous to clk.
- d0  in  10  raw channel-0 TMDS word, new word every clk.
- pll_delay  out  4  PLL fine-delay setting.
- slip_phase  out  4  current word phase, 0..9.
- slip  out  1  one-cycle strobe, asserted in the cycle `slip_phase` advances.
- aligned  out  1  high in LOCKED state.
- search_fail  out  1  sticky flag: a full sweep completed without alignment.
- hit_count  out  16  hit count of the last completed window, saturating.

Behaviour:
- Clock and reset: single clock `clk`; reset synchronous active-high.
- Reset values: state IDLE; `pll_delay` = DEFAULT_DELAY; `slip_phase` = 0; `slip` = 0; `aligned` = 0; `search_fail` = 0; `hit_count` = 0; internal counters 0.
- Hit definition: `d0` equals one of 0x354, 0x0AB, 0x154, 0x2AB in a MEASURE or LOCKED cycle.
- Hit counter: 16 bits, saturates at 0xFFFF.
- States:
  - IDLE: wait for `locked` = 1, then go to SETTLE.
  - SETTLE: count SETTLE cycles, ignoring `d0`; then go to MEASURE with window and hit counters cleared.
  - MEASURE: count WINDOW cycles. The cycle after the last sample is EVAL: `hit_count` is loaded with the hits.
    - hits ≥ THRESH → LOCKED; `aligned` = 1 from the next cycle; `search_fail` cleared.
    - hits < THRESH → STEP.
  - STEP (one cycle): `slip_phase` += 1 mod 10 and `slip` = 1 for this cycle.
    - On wrap 9→0, `pll_delay` += 1 mod 16 (under the macro, see below).
    - If the new (delay, phase) equals the pair the sweep started from, set `search_fail`.
    - Next state is SETTLE.
  - LOCKED: continuous back-to-back windows of WINDOW cycles; `hit_count` is updated at each window end.
    - A bad window (hits < THRESH) increments the miss counter; a good window clears it.
    - When the miss counter reaches LOSS_WINDOWS: `aligned` → 0 and go to STEP; the sweep start point is recorded as the current (delay, phase).
- Sweep start point: recorded on IDLE→SETTLE and on LOCKED→STEP.
- Priority: `reset` > (`locked` = 0) > everything else.
  - `locked` = 0 in any state → IDLE next cycle, `aligned` = 0.
  - `pll_delay`, `slip_phase` and `search_fail` hold their values (not reset).
- After `search_fail` is set, the search keeps wrapping. The flag stays set until LOCKED or reset.
- `slip` is never asserted outside STEP. Exactly one strobe per phase change.
- Latency: first possible `aligned` = SETTLE + WINDOW + 2 cycles after `locked` rises.

Optional Feature:
- Macro: TMDS_ALIGN_DELAY_SWEEP_EN.
- Defined: the search covers 16 delays × 10 phases = 160 candidates; `pll_delay` steps on phase wrap.
- Undefined: `pll_delay` is constant DEFAULT_DELAY; only 10 phases are searched; `search_fail` is set after 10 failed steps.

Test Plan (WINDOW=64, THRESH=8, SETTLE=4, LOSS_WINDOWS=2, macro defined):
- `locked`=1, `d0` = 0x2AB for 20 of every 64 cycles from start → `aligned`=1 at cycle 70 after `locked`; `hit_count`=20; `slip` never pulses.
- `d0` random data (no tokens) for 3 windows, then tokens → exactly 3 `slip` pulses; `slip_phase`=3; `pll_delay`=0; then `aligned`=1.
- No tokens ever → `pll_delay` steps 0→1 on the 10th STEP; `search_fail`=1 after 160 STEPs with (`pll_delay`, `slip_phase`) = (0,0); search continues.
- In LOCKED: one bad window then a good one → `aligned` stays 1. Two consecutive bad windows → `aligned`=0 and one `slip` pulse on the following cycle.
- Drop `locked` mid-MEASURE → IDLE next cycle, no `slip`, `pll_delay`/`slip_phase` unchanged. Assert `reset` the same cycle as a token window end → all outputs at reset values.
- Macro undefined, no tokens → `pll_delay` stays DEFAULT_DELAY; `search_fail`=1 after 10 STEPs.

Source files
------------

// File: rtl/tmds_align_ctrl.sv
// tmds_align_ctrl
//   Word-alignment controller for the HDMI raw capture path. It counts TMDS
//   control tokens on raw channel-0 words over fixed windows, and steps the
//   word phase (bit slip) and PLL fine delay until tokens arrive at the
//   expected rate. Once aligned, it keeps watching and re-searches after
//   LOSS_WINDOWS consecutive bad windows.
//
//   Build option: define TMDS_ALIGN_DELAY_SWEEP_EN to sweep pll_delay as well
//   (16 delays x 10 phases). Without it pll_delay is fixed at DEFAULT_DELAY
//   and only the 10 word phases are searched.
//
// Ports
//   clk          recovered TMDS pixel clock
//   reset        synchronous, active-high reset
//   locked       PLL lock level; low forces IDLE
//   d0[9:0]      raw channel-0 word, one per clk
//   pll_delay    PLL fine-delay setting
//   slip_phase   current word phase, 0..9
//   slip         one-cycle strobe in the cycle slip_phase takes its new value
//   aligned      high while LOCKED
//   search_fail  sticky: a full sweep returned to its start without locking
//   hit_count    token hits of the last completed window (saturating)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for PLL lock
// S_SETTLE  | ignoring d0 for SETTLE cycles after a lock/delay/phase change
// S_MEASURE | counting token hits over one WINDOW
// S_EVAL    | publish hit_count, decide LOCKED or STEP
// S_STEP    | slip strobe; phase/delay already advanced on entry
// S_LOCKED  | aligned; back-to-back windows with miss counting

module tmds_align_ctrl #(
    parameter int          WINDOW        = 4096,
    parameter int          THRESH        = 64,
    parameter int          SETTLE        = 256,
    parameter int          LOSS_WINDOWS  = 4,
    parameter logic [3:0]  DEFAULT_DELAY = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        locked,
    input  logic [9:0]  d0,
    output logic [3:0]  pll_delay,
    output logic [3:0]  slip_phase,
    output logic        slip,
    output logic        aligned,
    output logic        search_fail,
    output logic [15:0] hit_count
);

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int MW   = $clog2(LOSS_WINDOWS + 1);

    localparam logic [TW-1:0] WIN_LOAD = TW'(WINDOW - 1);
    localparam logic [TW-1:0] SET_LOAD = TW'(SETTLE - 1);
    localparam logic [15:0]   THRESH_V = 16'(THRESH);
    localparam logic [MW-1:0] LOSS_V   = MW'(LOSS_WINDOWS);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_MEASURE, S_EVAL, S_STEP, S_LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     hits_q, hits_d, hits_inc;
    logic [MW-1:0]   miss_q, miss_d, miss_inc;
    logic [3:0]      phase_q, phase_d, phase_step;
    logic [3:0]      start_phase_q, start_phase_d;
    logic            fail_q, fail_d;
    logic            slip_q, slip_d;
    logic [15:0]     hit_count_q, hit_count_d;
    logic            is_token;
    logic            enter_step;
    logic            start_match;

`ifdef TMDS_ALIGN_DELAY_SWEEP_EN
    logic [3:0]      delay_q, delay_d, delay_step;
    logic [3:0]      start_delay_q, start_delay_d;
`endif

    assign is_token = (d0 == 10'h354) || (d0 == 10'h0AB) ||
                      (d0 == 10'h154) || (d0 == 10'h2AB);

    assign hits_inc   = (hits_q == 16'hFFFF) ? hits_q : hits_q + 16'(is_token);
    assign miss_inc   = miss_q + MW'(1);
    assign phase_step = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;

`ifdef TMDS_ALIGN_DELAY_SWEEP_EN
    assign delay_step  = (phase_q == 4'd9) ? delay_q + 4'd1 : delay_q;
    // Compared against the start point as it will be after this cycle, so a
    // LOCKED->STEP transition that re-records the start is handled correctly.
    assign start_match = (phase_step == start_phase_d) && (delay_step == start_delay_d);
`else
    assign start_match = (phase_step == start_phase_d);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            hits_q        <= '0;
            miss_q        <= '0;
            phase_q       <= '0;
            start_phase_q <= '0;
            fail_q        <= 1'b0;
            slip_q        <= 1'b0;
            hit_count_q   <= '0;
`ifdef TMDS_ALIGN_DELAY_SWEEP_EN
            delay_q       <= DEFAULT_DELAY;
            start_delay_q <= DEFAULT_DELAY;
`endif
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            hits_q        <= hits_d;
            miss_q        <= miss_d;
            phase_q       <= phase_d;
            start_phase_q <= start_phase_d;
            fail_q        <= fail_d;
            slip_q        <= slip_d;
            hit_count_q   <= hit_count_d;
`ifdef TMDS_ALIGN_DELAY_SWEEP_EN
            delay_q       <= delay_d;
            start_delay_q <= start_delay_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        hits_d        = hits_q;
        miss_d        = miss_q;
        phase_d       = phase_q;
        start_phase_d = start_phase_q;
        fail_d        = fail_q;
        slip_d        = 1'b0;
        hit_count_d   = hit_count_q;
        enter_step    = 1'b0;
`ifdef TMDS_ALIGN_DELAY_SWEEP_EN
        delay_d       = delay_q;
        start_delay_d = start_delay_q;
`endif

        if (!locked) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d       = S_SETTLE;
                    timer_d       = SET_LOAD;
                    start_phase_d = phase_q;
`ifdef TMDS_ALIGN_DELAY_SWEEP_EN
                    start_delay_d = delay_q;
`endif
                end
                S_SETTLE: begin
                    if (timer_q == '0) begin
                        state_d = S_MEASURE;
                        timer_d = WIN_LOAD;
                        hits_d  = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_MEASURE: begin
                    hits_d = hits_inc;
                    if (timer_q == '0) state_d = S_EVAL;
                    else               timer_d = timer_q - TW'(1);
                end
                S_EVAL: begin
                    hit_count_d = hits_q;
                    if (hits_q >= THRESH_V) begin
                        state_d = S_LOCKED;
                        fail_d  = 1'b0;
                        timer_d = WIN_LOAD;
                        hits_d  = '0;
                        miss_d  = '0;
                    end else begin
                        state_d    = S_STEP;
                        enter_step = 1'b1;
                    end
                end
                S_STEP: begin
                    state_d = S_SETTLE;
                    timer_d = SET_LOAD;
                end
                S_LOCKED: begin
                    if (timer_q == '0) begin
                        // Window end: this cycle's sample is included.
                        hit_count_d = hits_inc;
                        hits_d      = '0;
                        timer_d     = WIN_LOAD;
                        if (hits_inc >= THRESH_V) begin
                            miss_d = '0;
                        end else if (miss_inc >= LOSS_V) begin
                            miss_d        = '0;
                            state_d       = S_STEP;
                            enter_step    = 1'b1;
                            start_phase_d = phase_q;
`ifdef TMDS_ALIGN_DELAY_SWEEP_EN
                            start_delay_d = delay_q;
`endif
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else begin
                        hits_d  = hits_inc;
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Phase/delay advance on entry so the new value and the strobe share
        // the STEP cycle.
        if (enter_step) begin
            phase_d = phase_step;
            slip_d  = 1'b1;
`ifdef TMDS_ALIGN_DELAY_SWEEP_EN
            delay_d = delay_step;
`endif
            if (start_match) fail_d = 1'b1;
        end
    end

    assign slip_phase  = phase_q;
    assign slip        = slip_q;
    assign aligned     = (state_q == S_LOCKED);
    assign search_fail = fail_q;
    assign hit_count   = hit_count_q;
`ifdef TMDS_ALIGN_DELAY_SWEEP_EN
    assign pll_delay   = delay_q;
`else
    assign pll_delay   = DEFAULT_DELAY;
`endif

endmodule

// File: tb/tb_tmds_align_ctrl.sv
module tb_tmds_align_ctrl;

    localparam int         WINDOW    = 64;
    localparam int         THRESH    = 8;
    localparam int         SETTLE    = 4;
    localparam int         LOSS      = 2;
    localparam logic [3:0] DEF_DELAY = 4'd0;
`ifdef TMDS_ALIGN_DELAY_SWEEP_EN
    localparam int N_CAND = 160;
    localparam bit SWEEP  = 1'b1;
`else
    localparam int N_CAND = 10;
    localparam bit SWEEP  = 1'b0;
`endif
    // IDLE/STEP cycle + SETTLE + WINDOW + EVAL cycle, then the next state.
    localparam int ROUND = SETTLE + WINDOW + 2;

    logic        clk = 1'b0;
    logic        reset, locked;
    logic [9:0]  d0;
    logic [3:0]  pll_delay, slip_phase;
    logic        slip, aligned, search_fail;
    logic [15:0] hit_count;

    int total = 0;
    int bad   = 0;
    int gcyc  = 0;
    int slip_cnt = 0;
    bit mode_pat = 1'b0;
    bit pat_mask [WINDOW];
    logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    always #5 clk = ~clk;

    tmds_align_ctrl #(
        .WINDOW(WINDOW), .THRESH(THRESH), .SETTLE(SETTLE),
        .LOSS_WINDOWS(LOSS), .DEFAULT_DELAY(DEF_DELAY)
    ) dut (
        .clk(clk), .reset(reset), .locked(locked), .d0(d0),
        .pll_delay(pll_delay), .slip_phase(slip_phase), .slip(slip),
        .aligned(aligned), .search_fail(search_fail), .hit_count(hit_count)
    );

    function automatic bit is_tok(logic [9:0] v);
        return (v == 10'h354) || (v == 10'h0AB) || (v == 10'h154) || (v == 10'h2AB);
    endfunction

    function automatic logic [9:0] pick_word();
        logic [9:0] v;
        if (mode_pat && pat_mask[gcyc % WINDOW]) begin
            v = toks[$urandom_range(3, 0)];
        end else begin
            v = 10'($urandom_range(1023, 0));
            while (is_tok(v)) v = 10'($urandom_range(1023, 0));
        end
        return v;
    endfunction

    // Period-WINDOW pattern with exactly k tokens: any WINDOW-long span holds k.
    task automatic set_pattern(input int k);
        int j;
        bit t;
        for (int i = 0; i < WINDOW; i++) pat_mask[i] = (i < k);
        for (int i = WINDOW - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = pat_mask[i];
            pat_mask[i] = pat_mask[j];
            pat_mask[j] = t;
        end
        mode_pat = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            d0 = pick_word();
            @(posedge clk);
            #1;
            gcyc++;
            if (slip === 1'b1) slip_cnt++;
        end
    endtask

    task automatic wait_aligned(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step(1);
            if (aligned === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_slip(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step(1);
            if (slip === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        locked   = 1'b0;
        mode_pat = 1'b0;
        step(2);
        reset    = 1'b0;
        slip_cnt = 0;
    endtask

    initial begin
        int n, k, kb, exp_phase, exp_delay;

        // Reset values
        do_reset();
        step(3);
        chk("rst_aligned", aligned, 0);
        chk("rst_slip", slip, 0);
        chk("rst_fail", search_fail, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_delay", pll_delay, DEF_DELAY);
        chk("rst_phase", slip_phase, 0);

        // Tokens from the start: first lock latency
        set_pattern(20);
        locked = 1'b1;
        wait_aligned(4 * ROUND, n);
        chk("t1_latency", n, ROUND);
        chk("t1_hits", hit_count, 20);
        chk("t1_noslip", slip_cnt, 0);
        chk("t1_phase", slip_phase, 0);

        // LOCKED windows: exact-threshold good, one bad, good, then two bad
        set_pattern(THRESH);
        step(WINDOW);
        chk("lk_thresh_hits", hit_count, THRESH);
        chk("lk_thresh_al", aligned, 1);
        set_pattern(THRESH - 1);
        step(WINDOW);
        chk("lk_bad1_hits", hit_count, THRESH - 1);
        chk("lk_bad1_al", aligned, 1);
        k = $urandom_range(WINDOW, THRESH);
        set_pattern(k);
        step(WINDOW);
        chk("lk_good_hits", hit_count, k);
        chk("lk_good_al", aligned, 1);
        mode_pat = 1'b0;
        step(WINDOW);
        chk("lk_bad2_hits", hit_count, 0);
        chk("lk_bad2_al", aligned, 1);
        kb = $urandom_range(THRESH - 1, 1);
        set_pattern(kb);
        step(WINDOW);
        chk("loss_al", aligned, 0);
        chk("loss_slip", slip, 1);
        chk("loss_hits", hit_count, kb);
        chk("loss_phase", slip_phase, 1);
        chk("loss_slipcnt", slip_cnt, 1);
        set_pattern($urandom_range(WINDOW, THRESH));
        wait_aligned(4 * ROUND, n);
        chk("relock_latency", n, ROUND);
        chk("relock_slipcnt", slip_cnt, 1);

        // Three bad rounds, then tokens
        do_reset();
        chk("rst2_phase", slip_phase, 0);
        set_pattern($urandom_range(THRESH - 1, 0));
        locked = 1'b1;
        step(3 * ROUND);
        chk("t2_slipcnt", slip_cnt, 3);
        k = $urandom_range(WINDOW, THRESH);
        set_pattern(k);
        wait_aligned(4 * ROUND, n);
        chk("t2_latency", n, ROUND);
        chk("t2_slipcnt_end", slip_cnt, 3);
        chk("t2_phase", slip_phase, 3);
        chk("t2_delay", pll_delay, DEF_DELAY);
        chk("t2_hits", hit_count, k);
        chk("t2_fail", search_fail, 0);

        // Drop locked in LOCKED, then mid-MEASURE
        locked = 1'b0;
        step(1);
        chk("drop_lk_al", aligned, 0);
        step(3);
        locked = 1'b1;
        step($urandom_range(55, 10));
        locked = 1'b0;
        n = slip_cnt;
        step(1);
        chk("drop_ms_al", aligned, 0);
        chk("drop_ms_slip", slip, 0);
        chk("drop_ms_phase", slip_phase, 3);
        chk("drop_ms_delay", pll_delay, DEF_DELAY);
        chk("drop_ms_slipcnt", slip_cnt, n);
        locked = 1'b1;
        wait_aligned(4 * ROUND, n);
        chk("drop_relock_latency", n, ROUND);
        chk("drop_relock_hits", hit_count, k);

        // Reset coinciding with a LOCKED window end
        step(WINDOW - 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rstwe_al", aligned, 0);
        chk("rstwe_hits", hit_count, 0);
        chk("rstwe_phase", slip_phase, 0);
        chk("rstwe_delay", pll_delay, DEF_DELAY);
        chk("rstwe_fail", search_fail, 0);
        chk("rstwe_slip", slip, 0);

        // No tokens: full sweep, search_fail, and continued wrapping
        do_reset();
        locked = 1'b1;
        for (int s = 1; s <= N_CAND + 3; s++) begin
            wait_slip(ROUND + 5, n);
            exp_phase = s % 10;
            exp_delay = SWEEP ? ((int'(DEF_DELAY) + s / 10) % 16) : int'(DEF_DELAY);
            chk($sformatf("sw_gap_%0d", s), n, ROUND);
            chk($sformatf("sw_phase_%0d", s), slip_phase, exp_phase);
            chk($sformatf("sw_delay_%0d", s), pll_delay, exp_delay);
            chk($sformatf("sw_fail_%0d", s), search_fail, (s >= N_CAND) ? 1 : 0);
        end
        chk("sw_slipcnt", slip_cnt, N_CAND + 3);
        set_pattern($urandom_range(WINDOW, THRESH));
        wait_aligned(4 * ROUND, n);
        chk("sw_lock_latency", n, ROUND);
        chk("sw_lock_fail_clr", search_fail, 0);
        chk("sw_lock_al", aligned, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
